// File: rtl/dcc_pkg.sv
// rtl/dcc_pkg.sv - shared types and constants for the dcc packet framer
package dcc_pkg;

  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, END} dcc_state_e;

  localparam logic [7:0] DCC_IDLE_ADDR        = 8'hFF;
  localparam logic [7:0] DCC_IDLE_DATA        = 8'h00;
  localparam int         DCC_DEFAULT_PREAMBLE = 14;

  function automatic logic [2:0] dcc_clamp_len(input logic [2:0] len, input logic [2:0] max_len);
    if (len < 3'd2) return 3'd2;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/dcc_byte_shifter.sv
// rtl/dcc_byte_shifter.sv - holds the bits of a byte still to follow the one on the line
module dcc_byte_shifter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       shift,
  output logic       next_bit,
  output logic       last_bit
);

  // bit 7 goes straight onto the line at load, so only bits 6..0 are kept
  logic [6:0] rest;
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rest <= '0;
      cnt  <= '0;
    end else if (load) begin
      rest <= load_byte[6:0];
      cnt  <= '0;
    end else if (shift) begin
      rest <= {rest[5:0], 1'b0};
      cnt  <= cnt + 3'd1;
    end
  end

  assign next_bit = rest[6];
  assign last_bit = (cnt == 3'd7);

endmodule

// File: rtl/dcc_packet_framer.sv
// rtl/dcc_packet_framer.sv - frames DCC packets (preamble, start bits, XOR byte, end bit) onto a bit stream
module dcc_packet_framer
  import dcc_pkg::*;
#(
  parameter int PREAMBLE_BITS = DCC_DEFAULT_PREAMBLE,
  parameter int MAX_BYTES     = 5,
  parameter int IDLE_FILL     = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [2:0]             pkt_len,
  input  logic [8*MAX_BYTES-1:0] pkt_data,
  output logic                   bit_valid,
  input  logic                   bit_ready,
  output logic                   bit_data,
  output logic                   busy,
  output logic                   len_err,
  output logic                   idle_sent
);

  localparam int         PRE_W   = $clog2(PREAMBLE_BITS + 1);
  localparam logic [2:0] MAX_LEN = 3'(MAX_BYTES);

  dcc_state_e       state;
  logic [PRE_W-1:0] pre_cnt;
  logic [2:0]       byte_idx;
  logic [2:0]       len_q;
  logic             is_idle;
  // data bytes followed by the error byte at index len_q
  logic [7:0]       pkt_bytes [8];

  logic [63:0] data_ext;
  logic [2:0]  len_c;
  logic [7:0]  err_c;
  logic [7:0]  cur_byte;
  logic        xfer;
  logic        sh_load;
  logic        sh_shift;
  logic        sh_next_bit;
  logic        sh_last_bit;

  assign data_ext = 64'(pkt_data);
  assign cur_byte = pkt_bytes[byte_idx];
  assign xfer     = bit_valid && bit_ready;
  assign sh_load  = xfer && (state == START);
  assign sh_shift = xfer && (state == DATA) && !sh_last_bit;

  always_comb begin
    len_c = dcc_clamp_len(pkt_len, MAX_LEN);
    err_c = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < len_c) err_c = err_c ^ data_ext[8*i +: 8];
    end
  end

  dcc_byte_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_byte (cur_byte),
    .shift     (sh_shift),
    .next_bit  (sh_next_bit),
    .last_bit  (sh_last_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pkt_ready <= 1'b0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b1;
      busy      <= 1'b0;
      len_err   <= 1'b0;
      idle_sent <= 1'b0;
      pre_cnt   <= '0;
      byte_idx  <= '0;
      len_q     <= 3'd2;
      is_idle   <= 1'b0;
    end else begin
      len_err   <= 1'b0;
      idle_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (!pkt_ready) begin
            pkt_ready <= 1'b1;
          end else if (pkt_valid || (IDLE_FILL != 0)) begin
            if (pkt_valid) begin
              for (int i = 0; i < 8; i++) begin
                pkt_bytes[i] <= (3'(i) < len_c)  ? data_ext[8*i +: 8] :
                                (3'(i) == len_c) ? err_c : 8'h00;
              end
              len_q   <= len_c;
              len_err <= (pkt_len != len_c);
              is_idle <= 1'b0;
            end else begin
              pkt_bytes[0] <= DCC_IDLE_ADDR;
              pkt_bytes[1] <= DCC_IDLE_DATA;
              pkt_bytes[2] <= DCC_IDLE_ADDR ^ DCC_IDLE_DATA;
              len_q        <= 3'd2;
              is_idle      <= 1'b1;
            end
            state     <= PREAMBLE;
            pkt_ready <= 1'b0;
            bit_valid <= 1'b1;
            bit_data  <= 1'b1;
            busy      <= 1'b1;
            pre_cnt   <= '0;
            byte_idx  <= '0;
          end
        end
        PREAMBLE: if (xfer) begin
          if (pre_cnt == PRE_W'(PREAMBLE_BITS - 1)) begin
            state    <= START;
            bit_data <= 1'b0;
          end else begin
            pre_cnt  <= pre_cnt + PRE_W'(1);
            bit_data <= 1'b1;
          end
        end
        START: if (xfer) begin
          state    <= DATA;
          bit_data <= cur_byte[7];
        end
        DATA: if (xfer) begin
          if (!sh_last_bit) begin
            bit_data <= sh_next_bit;
          end else if (byte_idx == len_q) begin
            state    <= END;
            bit_data <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= START;
            bit_data <= 1'b0;
          end
        end
        END: if (xfer) begin
          state     <= IDLE;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          pkt_ready <= 1'b1;
          idle_sent <= is_idle;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcc_packet_framer.sv
// tb/tb_dcc_packet_framer.sv - directed self-checking bench for dcc_packet_framer
module tb_dcc_packet_framer;

  localparam int PRE  = 14;
  localparam int MAXB = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            pkt_valid = 1'b0;
  logic            pkt_ready;
  logic [2:0]      pkt_len = 3'd0;
  logic [8*MAXB-1:0] pkt_data = '0;
  logic            bit_valid;
  logic            bit_ready = 1'b1;
  logic            bit_data;
  logic            busy;
  logic            len_err;
  logic            idle_sent;

  int total = 0;
  int bad   = 0;
  bit got_q[$];
  bit exp_q[$];
  int busy_cyc = 0, len_err_cnt = 0, idle_cnt = 0, stab_err = 0;
  bit bp_mode = 1'b0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_d = 1'b0;
  int ib;

  always #5 clk = ~clk;

  dcc_packet_framer #(.PREAMBLE_BITS(PRE), .MAX_BYTES(MAXB), .IDLE_FILL(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_len   (pkt_len),
    .pkt_data  (pkt_data),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_data  (bit_data),
    .busy      (busy),
    .len_err   (len_err),
    .idle_sent (idle_sent)
  );

  // bit_ready is chosen here, then the transfer due at the next rising edge is logged
  always @(negedge clk) begin
    bit_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset_n) begin
      if (prev_v && !prev_r && (!bit_valid || bit_data !== prev_d)) stab_err++;
      if (bit_valid && bit_ready) got_q.push_back(bit_data);
      if (busy) busy_cyc++;
      if (len_err) len_err_cnt++;
      if (idle_sent) idle_cnt++;
    end
    prev_v = reset_n && bit_valid;
    prev_r = bit_ready;
    prev_d = bit_data;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_exp(input int n, input logic [47:0] v);
    for (int i = 0; i < PRE; i++) exp_q.push_back(1'b1);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(1'b0);
      for (int j = 7; j >= 0; j--) exp_q.push_back(v[8*k + j]);
    end
    exp_q.push_back(1'b1);
  endtask

  task automatic check_stream(input string tag);
    int d = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (d < 0 && got_q[i] != exp_q[i]) d = i;
    check({tag, "_nbits"}, got_q.size(), exp_q.size());
    check({tag, "_first_diff"}, d, -1);
  endtask

  // called just after a rising edge; returns having seen the accepting edge
  task automatic send(input logic [2:0] len, input logic [39:0] data, output int idle_before);
    int n = 0;
    idle_cnt  = 0;
    pkt_len   = len;
    pkt_data  = data;
    pkt_valid = 1'b1;
    while (!pkt_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", int'(n < 2000), 1);
    @(posedge clk); #1;
    pkt_valid   = 1'b0;
    idle_before = idle_cnt;
    got_q.delete();
    busy_cyc = 0; len_err_cnt = 0; idle_cnt = 0; stab_err = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", int'(n < 5000), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_ready", int'(pkt_ready), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_bit_data",  int'(bit_data), 1);
    check("rst_busy",      int'(busy), 0);
    check("rst_len_err",   int'(len_err), 0);
    check("rst_idle_sent", int'(idle_sent), 0);

    pkt_valid = 1'b1;
    pkt_len   = 3'd2;
    pkt_data  = 40'h64_03;
    reset_n   = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", int'(pkt_ready), 1);

    // basic packet, offered before idle fill could start
    send(3'd2, 40'h64_03, ib);
    check("lat_bit_valid", int'(bit_valid), 1);
    check("lat_bit_data",  int'(bit_data), 1);
    check("lat_pkt_ready", int'(pkt_ready), 0);
    check("lat_busy",      int'(busy), 1);
    check("basic_idle_before", ib, 0);
    wait_done();
    exp_q.delete(); add_exp(3, 48'h67_64_03);
    check_stream("basic");
    check("basic_busy_cyc", busy_cyc, 42);
    check("basic_len_err", len_err_cnt, 0);
    check("basic_idle_sent", idle_cnt, 0);

    // two idle packets back to back
    got_q.delete(); idle_cnt = 0;
    for (int n = 0; n < 1000 && idle_cnt < 2; n++) begin
      @(posedge clk); #1;
    end
    check("idle_pulses", idle_cnt, 2);
    exp_q.delete(); add_exp(3, 48'hFF_00_FF); add_exp(3, 48'hFF_00_FF);
    check_stream("idle");

    // offered while an idle packet runs: taken in the very next IDLE slot
    send(3'd2, 40'h64_03, ib);
    check("prio_idle_before", ib, 1);
    wait_done();
    exp_q.delete(); add_exp(3, 48'h67_64_03);
    check_stream("prio");
    check("prio_idle_sent", idle_cnt, 0);

    bp_mode = 1'b1;
    send(3'd2, 40'h64_03, ib);
    wait_done();
    bp_mode = 1'b0;
    check_stream("bp");
    check("bp_stable", stab_err, 0);

    send(3'd0, 40'h64_03, ib);
    wait_done();
    check_stream("len0");
    check("len0_len_err", len_err_cnt, 1);

    send(3'd7, 40'h10_08_04_02_01, ib);
    wait_done();
    exp_q.delete(); add_exp(6, 48'h1F_10_08_04_02_01);
    check_stream("len7");
    check("len7_len_err", len_err_cnt, 1);

    // reset in the middle of a packet
    send(3'd2, 40'h64_03, ib);
    for (int n = 0; n < 500 && got_q.size() < 20; n++) begin
      @(posedge clk); #1;
    end
    check("mid_reached_20", int'(got_q.size() >= 20), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_bit_valid", int'(bit_valid), 0);
    check("mid_busy", int'(busy), 0);
    reset_n = 1'b1;
    send(3'd2, 40'h64_03, ib);
    check("post_rst_idle_before", ib, 0);
    wait_done();
    exp_q.delete(); add_exp(3, 48'h67_64_03);
    check_stream("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
